load_store_unit: RTL

Load/store unit sitting directly downstream of the execute stage. It consumes the ALU address and the rs2 store data and drives a handshaked data-memory bus, replacing the ideal single-cycle data_mem path. It handles byte, halfword and word accesses: lane steering, byte enables, and sign/zero extension. While an access is outstanding it stalls the core and reports misaligned or illegal accesses.

---
 rtl/load_store_unit_pkg.sv | 31 +++
 rtl/load_store_unit_if.sv | 18 +
 rtl/load_store_unit_align.sv | 73 +++++++
 rtl/load_store_unit.sv | 133 +++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: RV32I funct3 codes,
// opcodes, FSM state encoding and a load-extension helper.
package load_store_unit_pkg;

  localparam int WIDTH  = 32;
  localparam int NUM_BE = WIDTH / 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ERR} lsu_state_t;

  function automatic logic [WIDTH-1:0] extend(input logic [15:0] val,
                                              input logic is_half,
                                              input logic is_signed);
    if (is_half)
      extend = is_signed ? {{16{val[15]}}, val} : {16'b0, val};
    else
      extend = is_signed ? {{24{val[7]}}, val[7:0]} : {24'b0, val[7:0]};
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-oriented data-memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if import load_store_unit_pkg::*; ();

  logic              req_valid;
  logic              req_ready;
  logic              we;
  logic [WIDTH-1:0]  addr;
  logic [WIDTH-1:0]  wdata;
  logic [NUM_BE-1:0] be;
  logic              rsp_valid;
  logic [WIDTH-1:0]  rdata;

  modport master (output req_valid, we, addr, wdata, be,
                  input  req_ready, rsp_valid, rdata);
  modport slave  (input  req_valid, we, addr, wdata, be,
                  output req_ready, rsp_valid, rdata);

endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: legality/alignment check and store steering for the
// incoming request, extraction and extension for the latched load.
module lsu_align import load_store_unit_pkg::*; (
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [WIDTH-1:0]  wdata,
  output logic              access_ok,
  output logic [WIDTH-1:0]  st_wdata,
  output logic [NUM_BE-1:0] st_be,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_addr_lo,
  input  logic [WIDTH-1:0]  rdata,
  output logic [WIDTH-1:0]  ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store codes share encodings with LB/LH/LW; only the unsigned loads are load-only.
  always_comb begin
    access_ok = 1'b0;
    case (funct3)
      F3_LB:   access_ok = 1'b1;
      F3_LH:   access_ok = ~addr_lo[0];
      F3_LW:   access_ok = (addr_lo == 2'b00);
      F3_LBU:  access_ok = ~is_store;
      F3_LHU:  access_ok = ~is_store & ~addr_lo[0];
      default: access_ok = 1'b0;
    endcase
  end

  always_comb begin
    st_be    = '1;
    st_wdata = wdata;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          st_be    = 4'b0001 << addr_lo;
          st_wdata = {4{wdata[7:0]}};
        end
        F3_SH: begin
          st_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{wdata[15:0]}};
        end
        default: begin
          st_be    = '1;
          st_wdata = wdata;
        end
      endcase
    end
  end

  always_comb begin
    ld_byte = rdata[7:0];
    case (ld_addr_lo)
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      2'd3:    ld_byte = rdata[31:24];
      default: ld_byte = rdata[7:0];
    endcase
    ld_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (ld_funct3)
      F3_LB:   ld_data = extend({8'b0, ld_byte}, 1'b0, 1'b1);
      F3_LBU:  ld_data = extend({8'b0, ld_byte}, 1'b0, 1'b0);
      F3_LH:   ld_data = extend(ld_half, 1'b1, 1'b1);
      F3_LHU:  ld_data = extend(ld_half, 1'b1, 1'b0);
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access on a handshaked word bus, stalling the
// core until completion and reporting illegal or misaligned accesses as faults.
module load_store_unit import load_store_unit_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [WIDTH-1:0]  req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              fault,
  load_store_unit_if.master bus
);

  lsu_state_t        state_q, state_d;
  logic [WIDTH-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [NUM_BE-1:0] be_q, be_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              is_store_q, is_store_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;

  logic              access_ok;
  logic [WIDTH-1:0]  st_wdata;
  logic [NUM_BE-1:0] st_be;
  logic [WIDTH-1:0]  ld_data;

  lsu_align u_align (
    .is_store   (req_is_store),
    .funct3     (req_funct3),
    .addr_lo    (req_addr[1:0]),
    .wdata      (req_wdata),
    .access_ok  (access_ok),
    .st_wdata   (st_wdata),
    .st_be      (st_be),
    .ld_funct3  (funct3_q),
    .ld_addr_lo (addr_lo_q),
    .rdata      (bus.rdata),
    .ld_data    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      funct3_q   <= '0;
      addr_lo_q  <= '0;
      is_store_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      funct3_q   <= funct3_d;
      addr_lo_q  <= addr_lo_d;
      is_store_q <= is_store_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    funct3_d   = funct3_q;
    addr_lo_d  = addr_lo_q;
    is_store_d = is_store_q;
    rdata_d    = rdata_q;

    stall      = 1'b0;
    rsp_valid  = 1'b0;
    fault      = 1'b0;
    rsp_rdata  = '0;

    case (state_q)
      IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          if (access_ok) begin
            addr_d     = {req_addr[WIDTH-1:2], 2'b00};
            wdata_d    = st_wdata;
            be_d       = st_be;
            funct3_d   = req_funct3;
            addr_lo_d  = req_addr[1:0];
            is_store_d = req_is_store;
            state_d    = REQ;
          end else begin
            state_d    = ERR;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus.req_ready)
          state_d = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (bus.rsp_valid) begin
          rdata_d = is_store_q ? '0 : ld_data;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        state_d   = IDLE;
      end
      ERR: begin
        rsp_valid = 1'b1;
        fault     = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus fields come straight from the latched request so they hold still under backpressure.
  assign bus.req_valid = (state_q == REQ);
  assign bus.we        = (state_q == REQ) & is_store_q;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.be        = be_q;

endmodule
